// File: rtl/zigzag_coef_reader_pkg.sv
// Shared constants, loader state type and the JPEG zigzag table.
// Each table entry is the raster position {row[2:0], col[2:0]}.
package zigzag_coef_reader_pkg;
    localparam int ADDR_W  = 15;
    localparam int COEF_W  = 10;
    localparam int WORD_W  = 80;
    localparam int MAX_BLK = 4096;
    localparam int CNT_W   = 13;
    localparam int BLK_W   = 12;

    typedef enum logic [1:0] {
        L_IDLE,
        L_READ,
        L_FILL
    } load_state_e;

    localparam logic [5:0] ZZ_TAB [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
endpackage

// File: rtl/zigzag_coef_reader_if.sv
// Coefficient stream towards the quantiser: valid/ready plus sideband.
interface zigzag_coef_reader_if;
    import zigzag_coef_reader_pkg::*;

    logic              coef_valid;
    logic              coef_ready;
    logic [COEF_W-1:0] coef_data;
    logic [5:0]        coef_index;
    logic              coef_last;
    logic [BLK_W-1:0]  block_num;

    modport master (
        output coef_valid, coef_data, coef_index, coef_last, block_num,
        input  coef_ready
    );

    modport slave (
        input  coef_valid, coef_data, coef_index, coef_last, block_num,
        output coef_ready
    );
endinterface

// File: rtl/zigzag_coef_reader_zigzag_rom.sv
// Zigzag index to raster row/column lookup.
module zigzag_rom
    import zigzag_coef_reader_pkg::*;
(
    input  logic [5:0] idx,
    output logic [2:0] row,
    output logic [2:0] col
);
    assign {row, col} = ZZ_TAB[idx];
endmodule

// File: rtl/zigzag_coef_reader.sv
// Streams 8x8 DCT blocks from SRAM in zigzag order through two
// ping-pong block buffers so loading overlaps draining.
module zigzag_coef_reader
    import zigzag_coef_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  blk_count,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    zigzag_coef_reader_if.master coef
);
    load_state_e       l_state, l_next;
    logic [2:0]        rd_q, cap_row_q;
    logic              cap_vld_q;
    logic [CNT_W-1:0]  cnt_q, loaded_q, sat_cnt;
    logic              wsel_q, rsel_q;
    logic [1:0]        full_q;
    logic [5:0]        idx_q;
    logic [BLK_W-1:0]  blk_q;
    logic [WORD_W-1:0] buf_q [2][8];
    logic [WORD_W-1:0] rd_word;
    logic [2:0]        zz_row, zz_col;
    logic              accept, go, fill, hs, blk_end, last_blk;

    assign accept  = start & ~busy;
    assign sat_cnt = (blk_count > CNT_W'(MAX_BLK)) ? CNT_W'(MAX_BLK)
                                                   : blk_count;
    // On the accepting edge the loader can already leave idle.
    assign go = accept ? (sat_cnt != '0)
                       : (busy & ~full_q[wsel_q] & (loaded_q < cnt_q));

    always_comb begin
        l_next = l_state;
        mem_en = 1'b0;
        fill   = 1'b0;
        unique case (l_state)
            L_IDLE: if (go) l_next = L_READ;
            L_READ: begin
                mem_en = 1'b1;
                if (rd_q == 3'd7) l_next = L_FILL;
            end
            L_FILL: begin
                fill   = 1'b1;
                l_next = L_IDLE;
            end
            default: l_next = L_IDLE;
        endcase
    end

    assign mem_addr = mem_en ? {loaded_q[BLK_W-1:0], rd_q} : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_state   <= L_IDLE;
            rd_q      <= '0;
            cap_vld_q <= 1'b0;
            cap_row_q <= '0;
            loaded_q  <= '0;
            wsel_q    <= 1'b0;
        end else begin
            l_state   <= l_next;
            cap_vld_q <= mem_en;
            cap_row_q <= rd_q;
            if (mem_en) rd_q <= rd_q + 3'd1;
            if (accept) begin
                loaded_q <= '0;
                wsel_q   <= 1'b0;
            end else if (fill) begin
                loaded_q <= loaded_q + CNT_W'(1);
                wsel_q   <= ~wsel_q;
            end
        end
    end

    // Row data arrives one cycle after its read; storage needs no reset.
    always_ff @(posedge clk) begin
        if (cap_vld_q) buf_q[wsel_q][cap_row_q] <= mem_rdata;
    end

    zigzag_rom u_rom (
        .idx (idx_q),
        .row (zz_row),
        .col (zz_col)
    );

    assign hs       = coef.coef_valid & coef.coef_ready;
    assign blk_end  = hs & (idx_q == 6'd63);
    assign last_blk = ({1'b0, blk_q} + CNT_W'(1)) == cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= '0;
            rsel_q <= 1'b0;
            idx_q  <= '0;
            blk_q  <= '0;
            cnt_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fill) full_q[wsel_q] <= 1'b1;
            if (accept) begin
                cnt_q  <= sat_cnt;
                busy   <= (sat_cnt != '0);
                done   <= (sat_cnt == '0);
                rsel_q <= 1'b0;
                idx_q  <= '0;
                blk_q  <= '0;
            end else if (hs) begin
                idx_q <= idx_q + 6'd1;
                if (blk_end) begin
                    full_q[rsel_q] <= 1'b0;
                    rsel_q         <= ~rsel_q;
                    blk_q          <= blk_q + BLK_W'(1);
                    if (last_blk) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end
        end
    end

    assign rd_word         = buf_q[rsel_q][zz_row];
    assign coef.coef_valid = full_q[rsel_q];
    assign coef.coef_data  = full_q[rsel_q]
                           ? rd_word[int'(zz_col)*COEF_W +: COEF_W] : '0;
    assign coef.coef_index = idx_q;
    assign coef.coef_last  = (idx_q == 6'd63);
    assign coef.block_num  = blk_q;
endmodule

// File: tb/tb_zigzag_coef_reader.sv
// Bench for zigzag_coef_reader: SRAM model, diagonal-walk zigzag model,
// per-cycle stream checker and directed/random scenarios.
module tb_zigzag_coef_reader;
    import zigzag_coef_reader_pkg::*;

    typedef struct {
        int data;
        int idx;
        int blk;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [12:0] blk_count = '0;
    logic        busy, done, mem_en;
    logic [14:0] mem_addr;
    logic [79:0] mem_rdata;

    zigzag_coef_reader_if coef ();

    zigzag_coef_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .blk_count (blk_count),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .coef      (coef)
    );

    always #5 clk = ~clk;

    logic [79:0] sram [32768];
    always @(posedge clk) if (mem_en) mem_rdata <= sram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc++;

    bit rnd_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        coef.coef_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int checks = 0, errors = 0;
    int zr [64], zc [64];
    beat_t expq [$];
    int got [512], gotblk [512], s1 [64];
    int nbeat, rd_cnt, first_v, done_cyc, exp_total;
    int t0 = 0, zdone_cyc = -1;
    bit saw_done, busy_seen, done_due, pv, pr;
    logic [29:0] hold_vec;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, req, cyc);
        end
    endtask

    function automatic int coef_of(int b, int r, int c);
        logic [79:0] w;
        logic [9:0]  v;
        w = sram[8*b + r];
        v = w[c*10 +: 10];
        return int'($signed(v));
    endfunction

    task automatic set_coef(int b, int r, int c, int v);
        logic [79:0] w;
        w = sram[8*b + r];
        w[c*10 +: 10] = 10'(v);
        sram[8*b + r] = w;
    endtask

    task automatic preload_pattern(int nb);
        for (int b = 0; b < nb; b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    set_coef(b, r, c, (64*b + 8*r + c) % 1024);
    endtask

    // Stream checker: every cycle the outputs are meaningful.
    always @(negedge clk) begin
        if (!reset) begin
            pv = 1'b0;
            done_due = 1'b0;
        end else begin
            chk("done", int'(done), int'(done_due || cyc == zdone_cyc));
            done_due = 1'b0;
            if (done) begin
                saw_done = 1'b1;
                done_cyc = cyc - t0;
            end
            if (busy) busy_seen = 1'b1;
            if (mem_en) begin
                chk("mem_addr", int'(mem_addr), rd_cnt);
                rd_cnt++;
            end
            if (pv && !pr)
                chk("hold", int'({coef.coef_valid, coef.coef_data,
                    coef.coef_index, coef.coef_last, coef.block_num}),
                    int'({1'b1, hold_vec[28:0]}));
            if (coef.coef_valid && first_v < 0) first_v = cyc - t0;
            if (coef.coef_valid && coef.coef_ready) begin
                if (expq.size() == 0) begin
                    chk("extra_beat", nbeat + 1, exp_total);
                end else begin
                    beat_t e;
                    e = expq.pop_front();
                    chk("data", int'($signed(coef.coef_data)), e.data);
                    chk("index", int'(coef.coef_index), e.idx);
                    chk("last", int'(coef.coef_last), int'(e.idx == 63));
                    chk("block", int'(coef.block_num), e.blk);
                    if (nbeat < 512) begin
                        got[nbeat] = int'($signed(coef.coef_data));
                        gotblk[nbeat] = int'(coef.block_num);
                    end
                    nbeat++;
                    if (expq.size() == 0) done_due = 1'b1;
                end
            end
            pv = coef.coef_valid;
            pr = coef.coef_ready;
            hold_vec = {coef.coef_valid, coef.coef_data, coef.coef_index,
                        coef.coef_last, coef.block_num};
        end
    end

    task automatic kick(int n);
        @(posedge clk);
        #1;
        expq.delete();
        for (int b = 0; b < n; b++)
            for (int k = 0; k < 64; k++)
                expq.push_back('{coef_of(b, zr[k], zc[k]), k, b});
        nbeat = 0; rd_cnt = 0; first_v = -1; done_cyc = -1;
        saw_done = 1'b0; busy_seen = 1'b0; exp_total = n * 64;
        blk_count = 13'(n);
        start = 1'b1;
        t0 = cyc;
        if (n == 0) zdone_cyc = t0 + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start", int'(busy), int'(n != 0));
    endtask

    task automatic wait_done(int budget);
        int k = 0;
        while (!saw_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("timeout", int'(saw_done), 1);
        repeat (3) @(negedge clk);
        chk("beats", nbeat, exp_total);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n = 0;
        int lit [6] = '{0, 1, 8, 16, 9, 2};
        for (int s = 0; s < 15; s++)
            for (int j = 0; j < 8; j++) begin
                int r, c;
                r = (s % 2 != 0) ? j : 7 - j;
                c = s - r;
                if (c >= 0 && c < 8) begin
                    zr[n] = r; zc[n] = c; n++;
                end
            end
        for (int a = 0; a < 64; a++) sram[a] = '0;
        preload_pattern(4);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_valid", int'(coef.coef_valid), 0);
        chk("rst_block", int'(coef.block_num), 0);
        reset = 1'b1;

        kick(1);
        wait_done(200);
        chk("s1_first_valid", first_v, 10);
        chk("s1_done_cycle", done_cyc, 74);
        chk("s1_reads", rd_cnt, 8);
        for (int i = 0; i < 6; i++) chk("s1_lit", got[i], lit[i]);
        chk("s1_beat63", got[63], 63);
        for (int i = 0; i < 64; i++) s1[i] = got[i];

        kick(2);
        wait_done(300);
        chk("s2_first_valid", first_v, 10);
        chk("s2_done_cycle", done_cyc, 138);
        chk("s2_reads", rd_cnt, 16);
        chk("s2_b1_0", got[64], 64);
        chk("s2_b1_1", got[65], 65);
        chk("s2_b1_2", got[66], 72);
        chk("s2_blk63", gotblk[63], 0);
        chk("s2_blk64", gotblk[64], 1);

        rnd_rdy = 1'b1;
        kick(1);
        wait_done(2000);
        for (int i = 0; i < 64; i++) chk("s3_seq", got[i], s1[i]);
        rnd_rdy = 1'b0;

        set_coef(0, 0, 0, 'h3FF);
        set_coef(0, 7, 7, 'h200);
        kick(1);
        wait_done(200);
        chk("s4_first", got[0], -1);
        chk("s4_last", got[63], -512);
        preload_pattern(1);

        kick(1);
        begin
            int k = 0;
            while (nbeat < 20 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        chk("s5_reach20", int'(nbeat >= 20), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("s5_busy", int'(busy), 0);
        chk("s5_done", int'(done), 0);
        chk("s5_mem_en", int'(mem_en), 0);
        chk("s5_addr", int'(mem_addr), 0);
        chk("s5_valid", int'(coef.coef_valid), 0);
        chk("s5_data", int'(coef.coef_data), 0);
        chk("s5_index", int'(coef.coef_index), 0);
        chk("s5_last", int'(coef.coef_last), 0);
        chk("s5_block", int'(coef.block_num), 0);
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        kick(1);
        wait_done(200);
        chk("s5_first_valid", first_v, 10);
        chk("s5_first_beat", got[0], 0);

        kick(0);
        repeat (4) @(negedge clk);
        chk("s6_reads", rd_cnt, 0);
        chk("s6_busy", int'(busy_seen), 0);
        chk("s6_done_cycle", done_cyc, 1);

        rnd_rdy = 1'b1;
        kick(1);
        repeat (15) @(posedge clk);
        #1;
        blk_count = 13'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2000);
        repeat (40) @(negedge clk);
        chk("s6_stray_reads", rd_cnt, 8);

        for (int it = 0; it < 3; it++) begin
            int nb;
            for (int a = 0; a < 32; a++)
                sram[a] = 80'({$urandom, $urandom, $urandom});
            nb = $urandom_range(2, 4);
            rnd_rdy = 1'($urandom_range(0, 1));
            kick(nb);
            wait_done(4000);
            chk("rand_reads", rd_cnt, 8 * nb);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/zigzag_coef_reader.md
Name: zigzag_coef_reader

Overview:
Reads 2D-DCT coefficient blocks back out of the 32768x80 output SRAM that the DCT stage fills, in the DCT writer's layout. It re-orders each 8x8 block into JPEG zigzag order and streams one 10-bit signed coefficient per cycle over a valid/ready interface. This is the consumer-side counterpart of the DCT writer and feeds the quantiser/entropy stage. Two ping-pong block buffers hide SRAM read latency.

Parameters:
ADDR_W, 15, SRAM address width (32768 words)
COEF_W, 10, bits per coefficient
WORD_W, 80, SRAM word width (8 x COEF_W)
MAX_BLK, 4096, blocks held in SRAM (32768/8)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begin readout of blk_count blocks from block 0
blk_count  in  13  number of blocks to read, 0..4096; values above 4096 saturate to 4096
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the final coefficient handshake
mem_en  out  1  SRAM read enable
mem_addr  out  15  SRAM read address
mem_rdata  in  80  SRAM read data, valid the cycle after mem_en
coef_valid  out  1  coef_data is valid
coef_ready  in  1  downstream accepts on valid&ready
coef_data  out  10  signed coefficient
coef_index  out  6  zigzag index 0..63
coef_last  out  1  high when coef_index==63
block_num  out  12  block currently being output

Behaviour:
- Reset (reset==0, asynchronous): all outputs 0; both buffer-full flags clear; counters 0; loader and drainer idle.
- Memory layout: block b, row r is at address 8b+r. Column c occupies bits [10c+9:10c].
- start is accepted only when busy==0 and is ignored otherwise. If blk_count==0, done pulses the next cycle, busy stays 0, and no reads are issued.
- Loader FSM states are L_IDLE, L_READ, L_FILL:
  - L_IDLE to L_READ when busy, the write buffer is empty, and blocks_loaded<blk_count.
  - L_READ issues 8 consecutive reads, one per cycle (mem_en=1, addr 8b..8b+7), and captures each returning row one cycle later.
  - After row 7 is captured: set full[wsel], toggle wsel, blocks_loaded++, return to L_IDLE.
- Drainer:
  - coef_valid = full[rsel].
  - coef_data = buf[rsel][zz_row(idx)][zz_col(idx)].
  - On valid&ready: idx++. At idx==63: clear full[rsel], toggle rsel, idx=0, block_num++.
  - When the final block completes: done=1 for one cycle, busy=0.
- Handshake: while valid is high and ready is low, coef_data, coef_index, coef_last and block_num hold stable. valid never drops without a handshake.
- Latency: start sampled at cycle 0 puts reads on cycles 1-8 and data captures on cycles 2-9. coef_valid first goes high at cycle 10.
- Steady state: with ready held high there are no bubbles between blocks. The next block loads in 9 cycles while the current one drains in 64.
- The loader setting one full flag and the drainer clearing the other full flag in the same cycle are independent. A single buffer is never written while it is full.
- Reset mid-operation: the stream aborts immediately with no done pulse. The next start restarts from block 0.

Decomposition:
- Shared package holds COEF_W, WORD_W, ADDR_W, the 64-entry zigzag table (index to {row[2:0],col[2:0]}, standard JPEG order), and the loader state enum.
- Sub-module zigzag_rom: combinational, idx[5:0] to row/col.

Test Plan:
- Preload coefficient(b,r,c)=(64b+8r+c) mod 1024, blk_count=1, ready=1. Required: coef_valid rises at cycle 10 after start; coef_data sequence 0,1,8,16,9,2,3,10,17,24,...,63; coef_last only at the 64th beat; done pulses one cycle after it.
- Same preload, blk_count=2, ready=1. Required: 128 consecutive valid cycles; block_num steps 0 to 1 at beat 64; block 1 first values 64,65,72; exactly 16 mem_en cycles.
- Toggle ready pseudo-randomly. Required: data held stable while ready=0; output equals the first scenario's sequence; no beat lost or duplicated.
- Coefficient word 10'h3FF at (0,0) and 10'h200 at (7,7). Required: first beat is -1 and beat 63 is -512.
- Assert reset low at beat 20 of block 0. Required: all outputs 0 asynchronously. A new start then gives first beat 0 at cycle 10.
- blk_count=0, and separately start pulsed while busy. Required: done the next cycle with no mem_en in the first case; the stray start in the second case has no effect.
